// File: rtl/alu_pkg.sv
// alu_pkg: ALU op encodings, default width and execute-stage FSM states.
package alu_pkg;
    localparam int XLEN_DEFAULT = 32;
    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SLTU = 4'b1001
    } alu_op_e;
    typedef enum logic {IDLE, SHIFT} state_e;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU; with SERIAL_SHIFT_EN the shifts pass src_a through
// because only zero-amount shifts are completed here.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result,
    output logic            o_illegal
);
`ifndef SERIAL_SHIFT_EN
    localparam int SW = $clog2(XLEN);
    logic [SW-1:0] w_shamt;
    assign w_shamt = i_b[SW-1:0];
`endif
    always_comb begin
        o_result  = '0;
        o_illegal = 1'b0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SLT:  o_result = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            OP_SLTU: o_result = {{(XLEN-1){1'b0}}, i_a < i_b};
`ifdef SERIAL_SHIFT_EN
            OP_SRL, OP_SRA, OP_SLL: o_result = i_a;
`else
            OP_SRL:  o_result = i_a >> w_shamt;
            OP_SRA:  o_result = $signed(i_a) >>> w_shamt;
            OP_SLL:  o_result = i_a << w_shamt;
`endif
            default: o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage with valid/ready handshake, flush and EX/MEM register.
// Optional SERIAL_SHIFT_EN replaces the barrel shifter by a one-bit-per-cycle FSM.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [RD_W-1:0] rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic [RD_W-1:0] rd_out,
    output logic            illegal_op
);
    logic [XLEN-1:0] w_result, w_ld_result;
    logic [RD_W-1:0] w_ld_rd;
    logic            w_illegal, w_ld_illegal, w_idle, w_accept, w_ld;
    logic            r_out_valid, r_zero, r_illegal;
    logic [XLEN-1:0] r_result;
    logic [RD_W-1:0] r_rd_out;

    alu_core #(.XLEN(XLEN)) u_core (
        .i_op     (alu_control),
        .i_a      (src_a),
        .i_b      (src_b),
        .o_result (w_result),
        .o_illegal(w_illegal)
    );

    assign in_ready = w_idle && (!r_out_valid || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;

`ifdef SERIAL_SHIFT_EN
    localparam int SW = $clog2(XLEN);
    state_e          r_state, w_state_nxt;
    logic [XLEN-1:0] r_sh, w_sh_step;
    logic [SW-1:0]   r_cnt;
    logic [3:0]      r_op;
    logic [RD_W-1:0] r_rd;
    logic            w_start, w_done;
    assign w_idle    = r_state == IDLE;
    assign w_start   = w_accept && (alu_control inside {OP_SRL, OP_SRA, OP_SLL}) && (src_b[SW-1:0] != '0);
    // The final step waits if the EX/MEM slot is still held by an unconsumed result.
    assign w_done    = (r_state == SHIFT) && (r_cnt == SW'(1)) && (!r_out_valid || out_ready) && !flush;
    assign w_sh_step = (r_op == OP_SLL) ? r_sh << 1 : {(r_op == OP_SRA) && r_sh[XLEN-1], r_sh[XLEN-1:1]};
    assign w_ld         = (w_accept && !w_start) || w_done;
    assign w_ld_result  = w_done ? w_sh_step : w_result;
    assign w_ld_rd      = w_done ? r_rd : rd_in;
    assign w_ld_illegal = w_done ? 1'b0 : w_illegal;
    always_comb begin
        w_state_nxt = r_state;
        if (flush)
            w_state_nxt = IDLE;
        else if (w_start)
            w_state_nxt = SHIFT;
        else if (w_done)
            w_state_nxt = IDLE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_rd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_sh  <= src_a;
                r_cnt <= src_b[SW-1:0];
                r_op  <= alu_control;
                r_rd  <= rd_in;
            end else if (r_state == SHIFT && r_cnt != SW'(1)) begin
                r_sh  <= w_sh_step;
                r_cnt <= r_cnt - SW'(1);
            end
        end
    end
`else
    assign w_idle       = 1'b1;
    assign w_ld         = w_accept;
    assign w_ld_result  = w_result;
    assign w_ld_rd      = rd_in;
    assign w_ld_illegal = w_illegal;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_rd_out    <= '0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_ld) begin
            r_out_valid <= 1'b1;
            r_result    <= w_ld_result;
            r_zero      <= w_ld_result == '0;
            r_rd_out    <= w_ld_rd;
            r_illegal   <= w_ld_illegal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign alu_result = r_result;
    assign zero       = r_zero;
    assign rd_out     = r_rd_out;
    assign illegal_op = r_illegal;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and random checks of alu_exec_stage against an arithmetic model.
module tb_alu_exec_stage;
    localparam int XLEN = 32;
    localparam int RD_W = 5;

    logic            clk = 1'b0, reset_n = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic            in_ready, out_valid, zero, illegal_op;
    logic [3:0]      alu_control = '0;
    logic [XLEN-1:0] src_a = '0, src_b = '0, alu_result;
    logic [RD_W-1:0] rd_in = '0, rd_out;
    int              tests = 0, fails = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .src_a(src_a), .src_b(src_b), .rd_in(rd_in),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .zero(zero), .rd_out(rd_out), .illegal_op(illegal_op)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {illegal, result} from the op definitions, using wide integer arithmetic
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua = a, ub = b, p2 = 64'd1 << b[4:0];
        logic [31:0] na = ~a;
        longint unsigned una = na;
        case (op)
            4'd0: return {1'b0, 32'(ua + ub)};
            4'd1: return {1'b0, 32'(ua + 64'h1_0000_0000 - ub)};
            4'd2: return {1'b0, a & b};
            4'd3: return {1'b0, a | b};
            4'd4: return {1'b0, a ^ b};
            4'd5: return {1'b0, 31'd0, int'(a) < int'(b)};
            4'd6: return {1'b0, 32'(ua / p2)};
            4'd7: return {1'b0, a[31] ? ~32'(una / p2) : 32'(ua / p2)};
            4'd8: return {1'b0, 32'(ua * p2)};
            4'd9: return {1'b0, 31'd0, ua < ub};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef SERIAL_SHIFT_EN
        return (op inside {4'd6, 4'd7, 4'd8} && b[4:0] != 5'd0) ? int'(b[4:0]) + 1 : 1;
`else
        return 1;
`endif
    endfunction

    // Called and returns at posedge+1; issues one op with out_ready=1 and checks its result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        logic [32:0] e = ref_alu(op, a, b);
        int lat = 1;
        alu_control = op; src_a = a; src_b = b; rd_in = rd; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            chk({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat(op, b)));
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_result"}, 64'(alu_result), 64'(e[31:0]));
        chk({tag, "_zero"}, 64'(zero), 64'(e[31:0] == 32'd0));
        chk({tag, "_rd"}, 64'(rd_out), 64'(rd));
        chk({tag, "_illegal"}, 64'(illegal_op), 64'(e[32]));
    endtask

    initial begin
        logic [32:0] e;
        logic [3:0]  op;
        logic [31:0] a, b;
        #1 reset_n = 1'b0;
        #2;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(alu_result), 64'd0);
        chk("reset_zero", 64'(zero), 64'd0);
        chk("reset_rd", 64'(rd_out), 64'd0);
        chk("reset_illegal", 64'(illegal_op), 64'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_7_m3", 4'd0, 32'd7, 32'hFFFF_FFFD, 5'd3);
        run_op("sub_5_5", 4'd1, 32'd5, 32'd5, 5'd4);
        run_op("slt_neg", 4'd5, 32'hFFFF_FFFF, 32'd1, 5'd5);
        run_op("sltu_neg", 4'd9, 32'hFFFF_FFFF, 32'd1, 5'd6);
        run_op("sra_4", 4'd7, 32'h8000_0000, 32'd4, 5'd7);
        run_op("sll_1_5", 4'd8, 32'd1, 32'd5, 5'd8);
        run_op("srl_31", 4'd6, 32'h8000_0000, 32'd31, 5'd9);
        run_op("sll_zero_amt", 4'd8, 32'h1234_5678, 32'h20, 5'd10);
        run_op("illegal_1011", 4'b1011, 32'd9, 32'd9, 5'd11);
        run_op("illegal_1111", 4'b1111, 32'd1, 32'd2, 5'd12);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = (i % 3 == 0) ? $urandom_range(0, 40) : $urandom;
            if (i % 5 == 0) b = a;
            run_op("rand", op, a, b, 5'($urandom));
        end

        // drain, then back-to-back single-cycle ops: one result per cycle
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op = (i % 2 == 0) ? 4'($urandom_range(0, 5)) : 4'd9;
            a = $urandom; b = $urandom;
            e = ref_alu(op, a, b);
            alu_control = op; src_a = a; src_b = b; rd_in = 5'(i); in_valid = 1'b1;
            #1 chk("b2b_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            chk("b2b_valid", 64'(out_valid), 64'd1);
            chk("b2b_result", 64'(alu_result), 64'(e[31:0]));
            chk("b2b_rd", 64'(rd_out), 64'(i));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_drain", 64'(out_valid), 64'd0);

        // backpressure: outputs hold and nothing is accepted
        out_ready = 1'b0;
        alu_control = 4'd0; src_a = 32'd100; src_b = 32'd23; rd_in = 5'd17; in_valid = 1'b1;
        @(posedge clk); #1;
        alu_control = 4'd1; src_a = 32'd1; src_b = 32'd1; rd_in = 5'd2;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_result", 64'(alu_result), 64'd123);
            chk("hold_rd", 64'(rd_out), 64'd17);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_consumed", 64'(out_valid), 64'd0);

        // flush after accept, then flush with a pending input
        out_ready = 1'b0;
        alu_control = 4'd3; src_a = 32'd5; src_b = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1;
        #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_kill", 64'(out_valid), 64'd0);
        in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drop", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("flush_drop_late", 64'(out_valid), 64'd0);

        // asynchronous reset mid-operation
        run_op("pre_reset", 4'd4, 32'hA5A5_0000, 32'h0000_5A5A, 5'd21);
        alu_control = 4'd8; src_a = 32'd1; src_b = 32'd10; rd_in = 5'd22; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("areset_valid", 64'(out_valid), 64'd0);
        chk("areset_result", 64'(alu_result), 64'd0);
        chk("areset_rd", 64'(rd_out), 64'd0);
        chk("areset_zero", 64'(zero), 64'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("areset_no_ghost", 64'(out_valid), 64'd0);
        run_op("post_reset", 4'd7, 32'hF000_000F, 32'd2, 5'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
